// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP32 field widths, constants and accumulator state type
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam logic [31:0]      POS_ZERO = 32'h0000_0000;
  localparam logic [31:0]      POS_INF  = 32'h7F80_0000;
  localparam logic [31:0]      NEG_INF  = 32'hFF80_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic exception;
    logic overflow;
    logic underflow;
  } fp_flags_t;

endpackage

// File: rtl/fp_accumulator_if.sv
// rtl/fp_accumulator_if.sv - product input and sum output handshakes of the accumulator
interface fp_accumulator_if #(
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             in_exception;
  logic             in_overflow;
  logic             in_underflow;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_exception;
  logic             out_overflow;
  logic             out_underflow;

  // Producer of products / consumer of sums.
  modport master (
    output in_valid, in_data, in_last, in_exception, in_overflow, in_underflow,
    output out_ready,
    input  in_ready,
    input  out_valid, out_sum, out_count, out_exception, out_overflow, out_underflow
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_data, in_last, in_exception, in_overflow, in_underflow,
    input  out_ready,
    output in_ready,
    output out_valid, out_sum, out_count, out_exception, out_overflow, out_underflow
  );

endinterface

// File: rtl/fp_adder.sv
// rtl/fp_adder.sv - combinational FP32 adder, round-to-nearest-even, flush-to-zero
module fp_adder
  import fp_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        exception_o
);

  logic              a_s, b_s;
  logic [EXP_W-1:0]  a_e, b_e;
  logic [FRAC_W-1:0] a_f, b_f;

  assign {a_s, a_e, a_f} = a_i;
  assign {b_s, b_e, b_f} = b_i;

  // Operand classes. A NaN accumulator or any exp=FF addend counts as +0.
  logic a_inf, a_nan, a_zero, a_sz;
  logic b_spec, b_inf, b_zero, b_sz;

  assign a_inf  = (a_e == EXP_MAX) && (a_f == '0);
  assign a_nan  = (a_e == EXP_MAX) && (a_f != '0);
  assign a_zero = (a_e == '0) || a_nan;
  assign a_sz   = a_nan ? 1'b0 : a_s;
  assign b_spec = (b_e == EXP_MAX);
  assign b_inf  = b_spec && (b_f == '0);
  assign b_zero = (b_e == '0) || b_spec;
  assign b_sz   = b_spec ? 1'b0 : b_s;

  logic              sx, sy;
  logic [EXP_W-1:0]  ex, ey, d;
  logic [23:0]       mx, my;
  logic [26:0]       y_ext, y_sh, n;
  logic [27:0]       s;
  logic [4:0]        lz;
  logic              found, zero_res, rnd_up;
  logic signed [9:0] e;
  logic [24:0]       r;
  logic [31:0]       fin_sum;
  logic              fin_ovf, fin_unf;

  // Finite path: both operands normal; larger magnitude becomes x, y is aligned into x.
  always_comb begin
    sx = a_s; sy = b_s; ex = a_e; ey = b_e;
    mx = {1'b1, a_f}; my = {1'b1, b_f};
    if ({b_e, b_f} > {a_e, a_f}) begin
      sx = b_s; sy = a_s; ex = b_e; ey = a_e;
      mx = {1'b1, b_f}; my = {1'b1, a_f};
    end
    d     = ex - ey;
    y_ext = {my, 3'b000};
    y_sh  = '0;
    if (d >= 8'd27) begin
      y_sh = 27'd1;
    end else begin
      y_sh = y_ext >> d;
      if ((y_ext & ((27'd1 << d) - 27'd1)) != '0) y_sh[0] = 1'b1;
    end

    e        = $signed({2'b00, ex});
    s        = '0;
    n        = '0;
    lz       = '0;
    found    = 1'b0;
    zero_res = 1'b0;
    if (sx == sy) begin
      s = {1'b0, mx, 3'b000} + {1'b0, y_sh};
      if (s[27]) begin
        n    = s[27:1];
        n[0] = s[1] | s[0];
        e    = e + 10'sd1;
      end else begin
        n = s[26:0];
      end
    end else begin
      s = {1'b0, mx, 3'b000} - {1'b0, y_sh};
      n = s[26:0];
      zero_res = (n == '0);
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (n[i]) found = 1'b1;
          else      lz = lz + 5'd1;
        end
      end
      n = n << lz;
      e = e - $signed({5'b00000, lz});
    end

    // Guard is n[2], round n[1], sticky n[0]; a carry out of rounding bumps the exponent.
    rnd_up = n[2] & (n[1] | n[0] | n[3]);
    r      = {1'b0, n[26:3]} + {24'd0, rnd_up};
    if (r[24]) e = e + 10'sd1;

    fin_ovf = 1'b0;
    fin_unf = 1'b0;
    fin_sum = POS_ZERO;
    if (zero_res) begin
      fin_sum = POS_ZERO;
    end else if (e >= 10'sd255) begin
      fin_ovf = 1'b1;
      fin_sum = sx ? NEG_INF : POS_INF;
    end else if (e <= 10'sd0) begin
      fin_unf = 1'b1;
      fin_sum = POS_ZERO;
    end else begin
      fin_sum = {sx, e[7:0], (r[24] ? r[23:1] : r[22:0])};
    end
  end

  // Special-case selection around the finite path.
  always_comb begin
    sum_o       = POS_ZERO;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    exception_o = 1'b0;
    if (a_inf && b_inf && (a_s != b_s)) begin
      sum_o       = POS_ZERO;
      exception_o = 1'b1;
    end else if (a_inf) begin
      sum_o       = a_s ? NEG_INF : POS_INF;
      exception_o = b_spec;
    end else begin
      exception_o = b_spec | a_nan;
      if (a_zero && b_zero) begin
        sum_o = {a_sz & b_sz, 31'd0};
      end else if (b_zero) begin
        sum_o = a_i;
      end else if (a_zero) begin
        sum_o = b_i;
      end else begin
        sum_o       = fin_sum;
        overflow_o  = fin_ovf;
        underflow_o = fin_unf;
      end
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// rtl/fp_accumulator.sv - streaming FP32 dot-product accumulator with sticky flags
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  fp_accumulator_if.slave   bus
);

  acc_state_e       state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fp_flags_t        flg_q, flg_d;

  logic [31:0] add_sum;
  logic        add_ovf, add_unf, add_exc;
  logic        beat;

  fp_adder u_adder (
    .a_i         (acc_q),
    .b_i         (bus.in_data),
    .sum_o       (add_sum),
    .overflow_o  (add_ovf),
    .underflow_o (add_unf),
    .exception_o (add_exc)
  );

  assign bus.in_ready      = (state_q != DONE);
  assign bus.out_valid     = (state_q == DONE);
  assign bus.out_sum       = acc_q;
  assign bus.out_count     = cnt_q;
  assign bus.out_exception = flg_q.exception;
  assign bus.out_overflow  = flg_q.overflow;
  assign bus.out_underflow = flg_q.underflow;

  assign beat = bus.in_valid & bus.in_ready;

  // State, accumulator, count and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= POS_ZERO;
      cnt_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      flg_q   <= flg_d;
    end
  end

  // Accept beats while idle/accumulating; hold the result in DONE until it is taken.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    flg_d   = flg_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          acc_d           = add_sum;
          cnt_d           = cnt_q + 1'b1;
          flg_d.exception = flg_q.exception | bus.in_exception | add_exc;
          flg_d.overflow  = flg_q.overflow  | bus.in_overflow  | add_ovf;
          flg_d.underflow = flg_q.underflow | bus.in_underflow | add_unf;
          state_d         = bus.in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          acc_d   = POS_ZERO;
          cnt_d   = '0;
          flg_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = POS_ZERO;
        cnt_d   = '0;
        flg_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// tb/tb_fp_accumulator.sv - directed vector bench for fp_accumulator
module tb_fp_accumulator;

  logic clk;
  logic rst;

  fp_accumulator_if #(.CNT_W(16)) bus ();

  fp_accumulator #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [2:0][31:0] d;
    logic [2:0]       exc;
    logic [2:0]       ovf;
    logic [2:0]       unf;
    logic [31:0]      sum;
    int               cnt;
    logic             e_exc;
    logic             e_ovf;
    logic             e_unf;
  } vec_t;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  vec_t vecs [16];

  function automatic vec_t mk(input int n, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [2:0] exc, input logic [2:0] ovf,
                              input logic [2:0] unf, input logic [31:0] sum, input int cnt,
                              input logic e_exc, input logic e_ovf, input logic e_unf);
    vec_t v;
    v.n = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.exc = exc; v.ovf = ovf; v.unf = unf;
    v.sum = sum; v.cnt = cnt;
    v.e_exc = e_exc; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid     = 1'b0;
    bus.in_data      = 32'h0;
    bus.in_last      = 1'b0;
    bus.in_exception = 1'b0;
    bus.in_overflow  = 1'b0;
    bus.in_underflow = 1'b0;
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d beat%0d in_ready", idx, i), {31'd0, bus.in_ready}, 32'd1);
      chk($sformatf("v%0d beat%0d out_valid", idx, i), {31'd0, bus.out_valid}, 32'd0);
      bus.in_valid     = 1'b1;
      bus.in_data      = v.d[i];
      bus.in_last      = (i == v.n - 1);
      bus.in_exception = v.exc[i];
      bus.in_overflow  = v.ovf[i];
      bus.in_underflow = v.unf[i];
    end
    @(negedge clk);
    idle_inputs();
    chk($sformatf("v%0d out_valid", idx), {31'd0, bus.out_valid}, 32'd1);
    chk($sformatf("v%0d in_ready_done", idx), {31'd0, bus.in_ready}, 32'd0);
    chk($sformatf("v%0d out_sum", idx), bus.out_sum, v.sum);
    chk($sformatf("v%0d out_count", idx), {16'd0, bus.out_count}, v.cnt);
    chk($sformatf("v%0d out_exception", idx), {31'd0, bus.out_exception}, {31'd0, v.e_exc});
    chk($sformatf("v%0d out_overflow", idx), {31'd0, bus.out_overflow}, {31'd0, v.e_ovf});
    chk($sformatf("v%0d out_underflow", idx), {31'd0, bus.out_underflow}, {31'd0, v.e_unf});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk($sformatf("v%0d released out_valid", idx), {31'd0, bus.out_valid}, 32'd0);
    chk($sformatf("v%0d released count", idx), {16'd0, bus.out_count}, 32'd0);
  endtask

  initial begin
    vec_t v;

    vecs[0]  = mk(3, 32'h3F800000, 32'h40000000, 32'h3F000000, 3'b000, 3'b000, 3'b000, 32'h40600000, 3, 0, 0, 0);
    vecs[1]  = mk(2, 32'h40400000, 32'hC0400000, 32'h0,        3'b000, 3'b000, 3'b000, 32'h00000000, 2, 0, 0, 0);
    vecs[2]  = mk(1, 32'hBF800000, 32'h0,        32'h0,        3'b000, 3'b000, 3'b000, 32'hBF800000, 1, 0, 0, 0);
    vecs[3]  = mk(2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0,        3'b000, 3'b000, 3'b000, 32'h7F800000, 2, 0, 1, 0);
    vecs[4]  = mk(2, 32'h3F800000, 32'h33800000, 32'h0,        3'b000, 3'b000, 3'b000, 32'h3F800000, 2, 0, 0, 0);
    vecs[5]  = mk(2, 32'h3F800000, 32'h3F800000, 32'h0,        3'b001, 3'b000, 3'b000, 32'h40000000, 2, 1, 0, 0);
    vecs[6]  = mk(2, 32'h3F800000, 32'h3F800000, 32'h0,        3'b000, 3'b000, 3'b000, 32'h40000000, 2, 0, 0, 0);
    vecs[7]  = mk(3, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'hBF800000, 3'b000, 3'b000, 3'b000, 32'h7F800000, 3, 0, 1, 0);
    vecs[8]  = mk(2, 32'h3F800000, 32'h33C00000, 32'h0,        3'b000, 3'b000, 3'b000, 32'h3F800001, 2, 0, 0, 0);
    vecs[9]  = mk(2, 32'h3F800001, 32'h33800000, 32'h0,        3'b000, 3'b000, 3'b000, 32'h3F800002, 2, 0, 0, 0);
    vecs[10] = mk(1, 32'h7F800000, 32'h0,        32'h0,        3'b000, 3'b000, 3'b000, 32'h00000000, 1, 1, 0, 0);
    vecs[11] = mk(2, 32'h00400000, 32'h3F800000, 32'h0,        3'b000, 3'b000, 3'b000, 32'h3F800000, 2, 0, 0, 0);
    vecs[12] = mk(2, 32'h00800000, 32'h80C00000, 32'h0,        3'b000, 3'b000, 3'b000, 32'h00000000, 2, 0, 0, 1);
    vecs[13] = mk(1, 32'h40000000, 32'h0,        32'h0,        3'b000, 3'b001, 3'b000, 32'h40000000, 1, 0, 1, 0);
    vecs[14] = mk(1, 32'h40000000, 32'h0,        32'h0,        3'b000, 3'b000, 3'b001, 32'h40000000, 1, 0, 0, 1);
    vecs[15] = mk(2, 32'hC0000000, 32'h3F800000, 32'h0,        3'b000, 3'b000, 3'b000, 32'hBF800000, 2, 0, 0, 0);

    rst           = 1'b1;
    bus.out_ready = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_sum", bus.out_sum, 32'h0);
    chk("reset out_count", {16'd0, bus.out_count}, 32'd0);
    chk("reset flags", {29'd0, bus.out_exception, bus.out_overflow, bus.out_underflow}, 32'd0);

    for (int k = 0; k < 16; k++) run_frame(k, vecs[k]);

    // Backpressure: result held while a new beat waits on in_valid during DONE.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F800000;
    bus.in_last  = 1'b1;
    @(negedge clk);
    bus.in_data = 32'h40000000;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d out_valid", c), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp%0d in_ready", c), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("bp%0d out_sum", c), bus.out_sum, 32'h3F800000);
      chk($sformatf("bp%0d out_count", c), {16'd0, bus.out_count}, 32'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp release out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    idle_inputs();
    chk("bp pending out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp pending out_sum", bus.out_sum, 32'h40000000);
    chk("bp pending out_count", {16'd0, bus.out_count}, 32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset in the middle of a frame discards the partial sum.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h3F800000;
    bus.in_last  = 1'b0;
    bus.in_exception = 1'b1;
    @(negedge clk);
    bus.in_data = 32'h40000000;
    bus.in_exception = 1'b0;
    @(negedge clk);
    idle_inputs();
    chk("mid count before reset", {16'd0, bus.out_count}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid reset out_count", {16'd0, bus.out_count}, 32'd0);
    chk("mid reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    v = mk(1, 32'h40000000, 32'h0, 32'h0, 3'b000, 3'b000, 3'b000, 32'h40000000, 1, 0, 0, 0);
    run_frame(99, v);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Streaming IEEE-754 single-precision accumulator that sits directly downstream of the floating-point multiplier in the MLP neuron datapath.
- Consumes one product per accepted beat and sums the products of one dot product, delimited by in_last.
- Presents the sum, the term count and sticky status flags on an output handshake for the activation stage.

Parameters:
CNT_W, 16, width of the term counter; the count wraps modulo 2^CNT_W.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  product beat valid
in_ready  output  1  accumulator can accept a beat
in_data  input  32  product, IEEE-754 single {sign, exp[7:0], frac[22:0]}
in_last  input  1  beat is the final term of the dot product
in_exception  input  1  multiplier exception flag for this beat
in_overflow  input  1  multiplier overflow flag for this beat
in_underflow  input  1  multiplier underflow flag for this beat
out_valid  output  1  sum valid
out_ready  input  1  consumer accepts the sum
out_sum  output  32  accumulated sum, IEEE-754 single
out_count  output  CNT_W  number of beats accumulated
out_exception  output  1  sticky OR of in_exception plus internal exception
out_overflow  output  1  sticky OR of in_overflow plus adder overflow
out_underflow  output  1  sticky OR of in_underflow plus adder underflow

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, accumulator=+0, out_valid=0, out_sum=0, out_count=0, all flags=0, in_ready=1.
- States:
  - IDLE: in_ready=1, accumulator=+0. An accepted beat (in_valid&in_ready) moves to ACCUM, or to DONE if in_last.
  - ACCUM: in_ready=1. Each accepted beat sets acc <= acc + in_data. Count and flags update on the same edge. An accepted in_last goes to DONE.
  - DONE: in_ready=0, out_valid=1, outputs held stable. On out_ready=1, return to IDLE on that edge; accumulator, count and flags clear.
- Latency: out_valid rises on the cycle after the in_last beat is accepted. Throughput is one beat per cycle while accumulating; there is one dead input cycle per dot product (DONE).
- No input/output overlap: in DONE in_ready=0, so an in_valid held during DONE is neither accepted nor lost.
- Adder arithmetic (sub-module, combinational, single cycle):
  - Align with guard/round/sticky bits; round to nearest, ties to even.
  - Subnormal operands are treated as signed zero. Subnormal results flush to +0 and set underflow.
  - Exact cancellation gives +0.
  - Exponent overflow gives ±inf (exp=FF, frac=0) and sets overflow. An infinite accumulator stays infinite (inf + finite = inf).
  - An in_data with exp=FF sets exception and is added as +0.
  - inf + opposite-sign inf gives +0 and sets exception.
- Flags: sticky for the whole dot product; OR of input flags of every accepted beat plus adder events.
- out_count: number of accepted beats including the last one; wraps modulo 2^CNT_W with no flag.
- Reset mid-operation: partial sum, count and flags are discarded; the next beat starts a new dot product.

Decomposition:
- Shared package fp_pkg: FP32 field widths (EXP_W=8, FRAC_W=23, BIAS=127), EXP_MAX=8'hFF, constants POS_ZERO, POS_INF, NEG_INF, and the state enum {IDLE, ACCUM, DONE}.
- One sub-module, fp_adder: combinational A+B giving sum, overflow, underflow and exception. It is reusable by later bias-add stages.

Test Plan:
- Sum of three: 0x3F800000, 0x40000000, 0x3F000000(last), back-to-back -> out_sum=0x40600000 (3.5), out_count=3, flags 0, out_valid on the cycle after the last beat.
- Cancellation and single-beat frames: 0x40400000 + 0xC0400000(last) -> out_sum=0x00000000. Next frame 0xBF800000(last) -> 0xBF800000, out_count=1.
- Overflow and ties: 0x7F7FFFFF + 0x7F7FFFFF(last) -> 0x7F800000, out_overflow=1. 0x3F800000 + 0x33800000(last) -> 0x3F800000 (tie to even).
- Flag propagation: beat 0x3F800000 with in_exception=1, then 0x3F800000(last) -> out_sum=0x40000000, out_exception=1. The next frame has flags cleared.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no beat consumed. After out_ready=1, the pending beat is accepted in IDLE on the following cycle.
- Reset mid-frame: two beats accepted, rst=1 for one cycle -> out_valid=0, count=0. Then 0x40000000(last) -> out_sum=0x40000000.
